// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [7:0]  PAD_BYTE   = 8'h00;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; a last byte mid-word
// flushes the word with PAD_BYTE fill.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic [31:0] word,
  output logic        word_ready,
  output logic        padded
);

  logic [1:0]  idx;
  logic [23:0] sr;
  logic        at_end;

  assign at_end     = (idx == 2'(WORD_BYTES - 1));
  assign word_ready = in_valid && (at_end || in_last);
  assign padded     = in_valid && in_last && !at_end;

  // Word is assembled from the bytes already held plus the byte being accepted now.
  always_comb begin
    word = '0;
    unique case (idx)
      2'd0:    word = {in_byte, PAD_BYTE, PAD_BYTE, PAD_BYTE};
      2'd1:    word = {sr[7:0], in_byte, PAD_BYTE, PAD_BYTE};
      2'd2:    word = {sr[15:0], in_byte, PAD_BYTE};
      default: word = {sr[23:0], in_byte};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
      sr  <= '0;
    end else if (in_valid) begin
      idx <= word_ready ? 2'd0 : idx + 2'd1;
      sr  <= {sr[15:0], in_byte};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time byte-stream to instruction-memory word writer; holds the CPU in
// reset until the load finishes. Optional IMEM_LOADER_CHECKSUM_EN adds an XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 500,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int unsigned CW         = $clog2(DEPTH_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic          last,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic          overflow,
  output logic          partial,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]   checksum,
`endif
  output logic [CW-1:0] word_count
);

  state_t      state;
  logic        fin;
  logic        accept;
  logic        full;
  logic        pk_valid;
  logic        pk_clr;
  logic [31:0] pk_word;
  logic        pk_ready;
  logic        pk_padded;

  assign accept   = byte_valid && byte_ready;
  assign full     = (word_count == CW'(DEPTH_WORDS));
  assign pk_valid = accept && !full;
  assign pk_clr   = start && (state != LOAD);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .in_valid   (pk_valid),
    .in_byte    (byte_in),
    .in_last    (last),
    .word       (pk_word),
    .word_ready (pk_ready),
    .padded     (pk_padded)
  );

  // The session ends one cycle after the last byte so its final write
  // completes (and wr_addr advances) before done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fin        <= 1'b0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
      overflow   <= 1'b0;
      partial    <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (wr_en) wr_addr <= wr_addr + 32'd4;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            byte_ready <= 1'b1;
            word_count <= '0;
            overflow   <= 1'b0;
            partial    <= 1'b0;
            wr_addr    <= BASE_ADDR;
            busy       <= 1'b1;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
          end
        end
        LOAD: begin
          if (pk_ready) begin
            wr_en      <= 1'b1;
            wr_data    <= pk_word;
            word_count <= word_count + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= checksum ^ pk_word;
`endif
          end
          if (pk_padded)     partial  <= 1'b1;
          if (accept && full) overflow <= 1'b1;
          if (accept && last) begin
            byte_ready <= 1'b0;
            fin        <= 1'b1;
          end
          if (fin) begin
            state    <= DONE;
            fin      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default depth and DEPTH_WORDS=2).
module tb_imem_loader;

  localparam int unsigned CW  = $clog2(500 + 1);
  localparam int unsigned CW2 = $clog2(2 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, byte_valid, last;
  logic [7:0]    byte_in;
  logic          byte_ready, wr_en, busy, done, cpu_hold, overflow, partial;
  logic [31:0]   wr_addr, wr_data;
  logic [CW-1:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum, checksum2;
`endif

  logic           s2_start, s2_valid, s2_last;
  logic [7:0]     s2_byte;
  logic           s2_ready, s2_wr_en, s2_busy, s2_done, s2_hold, s2_ovf, s2_part;
  logic [31:0]    s2_addr, s2_data;
  logic [CW2-1:0] s2_count;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .last(last), .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .cpu_hold(cpu_hold),
    .overflow(overflow), .partial(partial),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .word_count(word_count)
  );

  imem_loader #(.DEPTH_WORDS(2), .BASE_ADDR(32'h0000_0000)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .byte_in(s2_byte), .byte_valid(s2_valid),
    .last(s2_last), .byte_ready(s2_ready), .wr_en(s2_wr_en), .wr_addr(s2_addr),
    .wr_data(s2_data), .busy(s2_busy), .done(s2_done), .cpu_hold(s2_hold),
    .overflow(s2_ovf), .partial(s2_part),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum(checksum2),
`endif
    .word_count(s2_count)
  );

  logic [31:0] la [0:31];
  logic [31:0] ld [0:31];
  int nwr = 0;
  int nwr2 = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1 && nwr < 32) begin
      la[nwr] = wr_addr;
      ld[nwr] = wr_data;
      nwr++;
    end
    if (s2_wr_en === 1'b1) nwr2++;
  end

  int tests = 0;
  int fails = 0;
  int m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    byte_in = b; byte_valid = 1'b1; last = l;
    step();
    byte_valid = 1'b0; last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, ".wr_en"},      32'(wr_en),      32'd0);
    chk({tag, ".wr_addr"},    wr_addr,         32'h0);
    chk({tag, ".wr_data"},    wr_data,         32'h0);
    chk({tag, ".busy"},       32'(busy),       32'd0);
    chk({tag, ".done"},       32'(done),       32'd0);
    chk({tag, ".cpu_hold"},   32'(cpu_hold),   32'd1);
    chk({tag, ".overflow"},   32'(overflow),   32'd0);
    chk({tag, ".partial"},    32'(partial),    32'd0);
    chk({tag, ".word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; last = 1'b0; byte_in = '0;
    s2_start = 1'b0; s2_valid = 1'b0; s2_last = 1'b0; s2_byte = '0;
    step(); step();
    chk_reset("rst");
    rst = 1'b0;
    step();
    chk("idle.byte_ready", 32'(byte_ready), 32'd0);

    // Full words 01..08
    pulse_start();
    chk("t1.byte_ready", 32'(byte_ready), 32'd1);
    chk("t1.busy",       32'(busy),       32'd1);
    m = nwr;
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    step(); step();
    chk("t1.nwr",      32'(nwr - m),       32'd2);
    chk("t1.addr0",    la[m],              32'h0);
    chk("t1.data0",    ld[m],              32'h01020304);
    chk("t1.addr1",    la[m+1],            32'h4);
    chk("t1.data1",    ld[m+1],            32'h05060708);
    chk("t1.count",    32'(word_count),    32'd2);
    chk("t1.done",     32'(done),          32'd1);
    chk("t1.busy",     32'(busy),          32'd0);
    chk("t1.cpu_hold", 32'(cpu_hold),      32'd0);
    chk("t1.partial",  32'(partial),       32'd0);
    chk("t1.wr_addr",  wr_addr,            32'h8);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t1.checksum", checksum,           32'h0404040C);
`endif

    // Partial last word AA..AF, and byte_valid ignored in DONE
    send(8'h55, 1'b0);
    step();
    chk("done.ignore", 32'(nwr - m), 32'd2);
    pulse_start();
    chk("t2.cpu_hold", 32'(cpu_hold),   32'd1);
    chk("t2.done",     32'(done),       32'd0);
    chk("t2.count",    32'(word_count), 32'd0);
    chk("t2.wr_addr",  wr_addr,         32'h0);
    m = nwr;
    for (int i = 0; i < 6; i++) send(8'hAA + 8'(i), i == 5);
    step(); step();
    chk("t2.nwr",     32'(nwr - m),    32'd2);
    chk("t2.addr0",   la[m],           32'h0);
    chk("t2.data0",   ld[m],           32'hAAABACAD);
    chk("t2.addr1",   la[m+1],         32'h4);
    chk("t2.data1",   ld[m+1],         32'hAEAF0000);
    chk("t2.partial", 32'(partial),    32'd1);
    chk("t2.done",    32'(done),       32'd1);

    // byte_valid toggling every other cycle
    pulse_start();
    chk("t3.partial_clr", 32'(partial), 32'd0);
    m = nwr;
    for (int i = 0; i < 8; i++) begin
      byte_in    = 8'h11 + 8'(i / 2);
      byte_valid = (i % 2 == 0);
      step();
      if (i == 5) chk("t3.no_early_wr", 32'(wr_en), 32'd0);
      if (i == 6) begin
        chk("t3.wr_en_lat", 32'(wr_en), 32'd1);
        chk("t3.wr_data",   wr_data,    32'h11121314);
        chk("t3.wr_addr",   wr_addr,    32'h0);
      end
      if (i == 7) chk("t3.one_pulse", 32'(wr_en), 32'd0);
    end
    byte_valid = 1'b0;
    step(); step();
    chk("t3.nwr", 32'(nwr - m), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("t3.start_ignored", 32'(word_count), 32'd1);
    send(8'h99, 1'b1);
    step(); step();
    chk("t3.nwr_end", 32'(nwr - m),   32'd2);
    chk("t3.addr1",   la[m+1],        32'h4);
    chk("t3.data1",   ld[m+1],        32'h99000000);
    chk("t3.count",   32'(word_count), 32'd2);
    chk("t3.partial", 32'(partial),   32'd1);

    // Capacity limit on the DEPTH_WORDS=2 instance
    s2_start = 1'b1; step(); s2_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s2_byte = 8'(i); s2_valid = 1'b1; s2_last = (i == 11);
      step();
      if (i == 7) chk("t4.ovf_before", 32'(s2_ovf), 32'd0);
      if (i == 8) chk("t4.ovf_set",    32'(s2_ovf), 32'd1);
    end
    s2_valid = 1'b0; s2_last = 1'b0;
    step(); step();
    chk("t4.nwr",      32'(nwr2),     32'd2);
    chk("t4.overflow", 32'(s2_ovf),   32'd1);
    chk("t4.done",     32'(s2_done),  32'd1);
    chk("t4.count",    32'(s2_count), 32'd2);
    chk("t4.wr_addr",  s2_addr,       32'h8);
    chk("t4.data",     s2_data,       32'h04050607);

    // Reset mid-session after 5 accepted bytes
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), 1'b0);
    rst = 1'b1;
    step();
    chk_reset("t5");
    rst = 1'b0;
    step();
    pulse_start();
    m = nwr;
    for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), i == 3);
    step(); step();
    chk("t5.nwr",   32'(nwr - m), 32'd1);
    chk("t5.addr",  la[m],        32'h0);
    chk("t5.data",  ld[m],        32'h31323334);
    chk("t5.done",  32'(done),    32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
